// File: rtl/sysref_ctrl_pkg.sv
// Shared definitions for the SYSREF sync controller.
//   state_e        : sequencer states
//   *_DEF          : default widths, lock count and timeout
package sysref_ctrl_pkg;

  localparam int unsigned PERIOD_W_DEF    = 16;
  localparam int unsigned NPULSE_W_DEF    = 8;
  localparam int unsigned LOCK_CNT_DEF    = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 65535;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    MEASURE,
    GATE,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/sysref_period_meter.sv
// SYSREF period meter: rise detector, saturating period counter,
// stored period and match comparator.
//   clk, rst_n  : clock, synchronous active-low reset
//   sysref_in   : SYSREF already registered in clk
//   clr         : restart the counter (sequence start)
//   store_en    : store the just-completed period on a rise
//   rise        : rising edge of sysref_in this cycle
//   period_ok   : just-completed period matches the stored period
//   timeout     : counter saturated at TIMEOUT_CYC without a rise
//   period      : stored (last measured) period
// Macro SYSREF_PERIOD_TOL_EN: periods within +/-1 count as matching.
module sysref_period_meter
  import sysref_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_W    = PERIOD_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sysref_in,
  input  logic                clr,
  input  logic                store_en,
  output logic                rise,
  output logic                period_ok,
  output logic                timeout,
  output logic [PERIOD_W-1:0] period
);

  localparam logic [PERIOD_W-1:0] TMO = PERIOD_W'(TIMEOUT_CYC);

  logic                sysref_q, sysref_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
`ifdef SYSREF_PERIOD_TOL_EN
  logic [PERIOD_W-1:0] diff;
`endif

  always_comb begin
    sysref_d = sysref_in;
    rise     = sysref_in & ~sysref_q;
    // cnt_q holds the length of the period that ends on this rise
    if (rise || clr) begin
      cnt_d = PERIOD_W'(1);
    end else if (cnt_q != TMO) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    period_d = (rise && store_en) ? cnt_q : period_q;
    timeout  = (cnt_q == TMO) && !rise;
`ifdef SYSREF_PERIOD_TOL_EN
    diff      = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
    period_ok = (diff <= PERIOD_W'(1));
`else
    period_ok = (cnt_q == period_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sysref_q <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      sysref_q <= sysref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign period = period_q;

endmodule

// File: rtl/sysref_sync_ctrl.sv
// PL SYSREF sequencer for RF-ADC/RF-DAC multi-tile sync. Measures the
// SYSREF period until LOCK_CNT consecutive periods match, then forwards
// exactly num_pulses whole pulses (1-cycle registered delay).
//   pl_clk, pl_resetn      : clock, synchronous active-low reset
//   sysref_in              : SYSREF registered in pl_clk
//   arm / abort            : start pulse / level forcing IDLE (abort wins)
//   num_pulses             : pulses to forward (0: DONE right after lock)
//   sysref_adc, sysref_dac : gated SYSREF outputs
//   busy, locked, done, error, period : status
// Macro SYSREF_PERIOD_TOL_EN: tolerate +/-1 cycle period jitter.
module sysref_sync_ctrl
  import sysref_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_W    = PERIOD_W_DEF,
  parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned NPULSE_W    = NPULSE_W_DEF
) (
  input  logic                pl_clk,
  input  logic                pl_resetn,
  input  logic                sysref_in,
  input  logic                arm,
  input  logic                abort,
  input  logic [NPULSE_W-1:0] num_pulses,
  output logic                sysref_adc,
  output logic                sysref_dac,
  output logic                busy,
  output logic                locked,
  output logic                done,
  output logic                error,
  output logic [PERIOD_W-1:0] period
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);

  state_e              state_q, state_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [NPULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [NPULSE_W-1:0] num_q, num_d;
  logic                fwd_q, fwd_d;
  logic                sysref_out_q, sysref_out_d;
  logic                busy_q, busy_d;
  logic                locked_q, locked_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic rise, period_ok, timeout, arm_go, store_en;

  always_comb begin
    arm_go   = arm && !abort && (state_q inside {IDLE, DONE, ERROR});
    store_en = state_q inside {MEASURE, GATE};
  end

  sysref_period_meter #(
    .PERIOD_W    (PERIOD_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_meter (
    .clk       (pl_clk),
    .rst_n     (pl_resetn),
    .sysref_in (sysref_in),
    .clr       (arm_go),
    .store_en  (store_en),
    .rise      (rise),
    .period_ok (period_ok),
    .timeout   (timeout),
    .period    (period)
  );

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    num_d       = num_q;
    // An accepted pulse keeps following sysref_in until it falls,
    // independent of the state, so it is never cut short.
    fwd_d        = fwd_q & sysref_in;
    sysref_out_d = fwd_q & sysref_in;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (arm_go) state_d = SEARCH;
      end
      SEARCH: begin
        if (timeout) begin
          state_d = ERROR;
        end else if (rise) begin
          state_d     = MEASURE;
          match_cnt_d = '0;
        end
      end
      MEASURE: begin
        if (timeout) begin
          state_d = ERROR;
        end else if (rise) begin
          if (!period_ok) begin
            match_cnt_d = '0;
          end else if (int'(match_cnt_q) + 1 >= int'(LOCK_CNT) - 1) begin
            state_d     = (num_pulses == '0) ? DONE : GATE;
            pulse_cnt_d = '0;
            num_d       = num_pulses;
          end else begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
          end
        end
      end
      GATE: begin
        if (timeout) begin
          state_d = ERROR;
        end else if (rise) begin
          if (!period_ok) begin
            state_d = ERROR;
          end else if (pulse_cnt_q < num_q) begin
            fwd_d        = 1'b1;
            sysref_out_d = 1'b1;
            pulse_cnt_d  = pulse_cnt_q + NPULSE_W'(1);
          end
        end else if (fwd_q && !sysref_in && pulse_cnt_q == num_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d      = IDLE;
      fwd_d        = 1'b0;
      sysref_out_d = 1'b0;
    end

    busy_d   = state_d inside {SEARCH, MEASURE, GATE};
    locked_d = state_d inside {GATE, DONE};
    done_d   = (state_d == DONE);
    error_d  = (state_d == ERROR);
  end

  always_ff @(posedge pl_clk) begin
    if (!pl_resetn) begin
      state_q      <= IDLE;
      match_cnt_q  <= '0;
      pulse_cnt_q  <= '0;
      num_q        <= '0;
      fwd_q        <= 1'b0;
      sysref_out_q <= 1'b0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      num_q        <= num_d;
      fwd_q        <= fwd_d;
      sysref_out_q <= sysref_out_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign sysref_adc = sysref_out_q;
  assign sysref_dac = sysref_out_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
